fetch_queue_mw: RTL

//  Parametrised multi-wide fetch buffer between I$ and ID; supersedes the single-slot IF instruction queue.

---
 rtl/fetch_queue_mw.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/fetch_queue_mw.sv
// Multi-wide fetch buffer: issues aligned I$ block requests, unpacks FETCH_W-wide
// responses into an in-order queue and hands one instruction per cycle to decode.
module fetch_queue_mw #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned MAX_OUT = 2,
  parameter logic [31:0] RST_PC  = 32'h0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       redirect_i,
  input  logic [31:0]                redirect_pc_i,
  output logic                       req_valid_o,
  output logic [31:0]                req_pc_o,
  input  logic                       req_ready_i,
  input  logic                       rsp_valid_i,
  input  logic [32*FETCH_W-1:0]      rsp_data_i,
  input  logic                       pred_taken_i,
  input  logic [$clog2(FETCH_W):0]   pred_slot_i,
  input  logic [31:0]                pred_target_i,
  output logic                       deq_valid_o,
  output logic [31:0]                deq_pc_o,
  output logic [31:0]                deq_inst_o,
  output logic                       deq_pred_o,
  input  logic                       deq_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned SLOT_W = $clog2(FETCH_W) + 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUT + 1);
  localparam int unsigned SF_W   = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [31:0] BLK_MASK  = 32'(FETCH_W * 4 - 1);
  localparam logic [31:0] BLK_BYTES = 32'(FETCH_W * 4);

  logic [31:0]        mem_pc   [DEPTH];
  logic [31:0]        mem_inst [DEPTH];
  logic [DEPTH-1:0]   mem_pred;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;

  logic [31:0]        fetch_pc;
  logic               started;
  logic [OUT_W-1:0]   outstanding, outstanding_nxt, drop_cnt;

  logic [31:0]        sf_base [MAX_OUT];
  logic [SLOT_W-1:0]  sf_off  [MAX_OUT];
  logic [SF_W-1:0]    sf_wr, sf_rd;

  logic [31:0]        fetch_base, free_slots, rsp_base;
  logic [SLOT_W-1:0]  fetch_off, rsp_off, last_slot, n_push;
  logic               req_fire, rsp_keep, taken, own_redir, pop;

  always_comb begin
    fetch_base      = fetch_pc & ~BLK_MASK;
    fetch_off       = SLOT_W'((fetch_pc & BLK_MASK) >> 2);
    free_slots      = 32'(DEPTH) - 32'(count);
    req_valid_o     = started && !redirect_i && (32'(outstanding) < MAX_OUT) &&
                      (free_slots >= FETCH_W * (32'(outstanding) + 32'd1));
    req_pc_o        = fetch_base;
    req_fire        = req_valid_o && req_ready_i;
    rsp_base        = sf_base[sf_rd];
    rsp_off         = sf_off[sf_rd];
    rsp_keep        = rsp_valid_i && (drop_cnt == '0) && !redirect_i;
    // A predicted slot before the entry offset lies outside the fetched range.
    taken           = pred_taken_i && (pred_slot_i >= rsp_off);
    own_redir       = rsp_keep && taken;
    last_slot       = taken ? pred_slot_i : SLOT_W'(FETCH_W - 1);
    n_push          = rsp_keep ? (last_slot - rsp_off + SLOT_W'(1)) : '0;
    deq_valid_o     = (count != '0);
    pop             = deq_valid_o && deq_ready_i;
    outstanding_nxt = outstanding + OUT_W'(req_fire) - OUT_W'(rsp_valid_i);
    deq_pc_o        = deq_valid_o ? mem_pc[rd_ptr]   : '0;
    deq_inst_o      = deq_valid_o ? mem_inst[rd_ptr] : '0;
    deq_pred_o      = deq_valid_o && mem_pred[rd_ptr];
    count_o         = count;
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned k = 0; k < FETCH_W; k++) begin
      if (rsp_keep && (k >= 32'(rsp_off)) && (k <= 32'(last_slot))) begin
        mem_pc[PTR_W'(32'(wr_ptr) + k - 32'(rsp_off))]   <= rsp_base + 4 * k;
        mem_inst[PTR_W'(32'(wr_ptr) + k - 32'(rsp_off))] <= rsp_data_i[32*k +: 32];
        mem_pred[PTR_W'(32'(wr_ptr) + k - 32'(rsp_off))] <= taken && (k == 32'(last_slot));
      end
    end
  end

  // Side FIFO keeps running across redirects: entries of responses that will be
  // dropped are popped unused, so drop_cnt alone marks them stale.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sf_wr <= '0;
      sf_rd <= '0;
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        sf_base[i] <= '0;
        sf_off[i]  <= '0;
      end
    end else begin
      if (req_fire) begin
        sf_base[sf_wr] <= fetch_base;
        sf_off[sf_wr]  <= fetch_off;
        sf_wr          <= (sf_wr == SF_W'(MAX_OUT - 1)) ? '0 : sf_wr + SF_W'(1);
      end
      if (rsp_valid_i) begin
        sf_rd <= (sf_rd == SF_W'(MAX_OUT - 1)) ? '0 : sf_rd + SF_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      started     <= 1'b0;
      fetch_pc    <= RST_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
    end else begin
      started     <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        fetch_pc <= redirect_pc_i;
        drop_cnt <= outstanding - OUT_W'(rsp_valid_i);
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(n_push);
        rd_ptr <= rd_ptr + PTR_W'(pop);
        count  <= count + (PTR_W+1)'(n_push) - (PTR_W+1)'(pop);
        if (own_redir) begin
          fetch_pc <= pred_target_i;
          drop_cnt <= outstanding_nxt;
        end else begin
          if (req_fire) fetch_pc <= fetch_base + BLK_BYTES;
          if (rsp_valid_i && (drop_cnt != '0)) drop_cnt <= drop_cnt - OUT_W'(1);
        end
      end
    end
  end

  a_rsp_has_request: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsp_valid_i |-> (outstanding != '0));

endmodule
